scard_rx_iso: RTL

- Next-generation smartcard (ISO 7816-3) character receiver for the smartcard interface.
- Runtime-programmable ETU divider and direct/inverse convention; parity checking (even/odd/off) and framing-error detection.
- Idle/end-of-packet detection, plus optional T=0 error-signal (NACK) generation.
- Sits between the I/O-line pad synchroniser and the smartcard byte FIFO/controller.

---
 rtl/scard_rx_iso.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/scard_rx_iso.sv
`timescale 1ns/1ps
// ISO 7816-3 character receiver: oversampled ETU timing, direct/inverse convention, parity, guard and idle/EOP detection.
// Define SCARD_RX_NACK_EN to add T=0 error signalling (NACK for one ETU, then a one-ETU hold-off).
module scard_rx_iso #(
  parameter int DIV_W     = 16,
  parameter int OVS       = 8,
  parameter int GAP_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_inverse,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_par_err,
  output logic             rx_frm_err,
  output logic             rx_idle,
  output logic             rx_eop,
  output logic             nack_oe
);

  localparam int OVS_W = $clog2(OVS);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [OVS_W-1:0] OVS_TOP  = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] HALF_TOP = OVS_W'(OVS / 2 - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(GAP_TICKS);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef SCARD_RX_NACK_EN
    , NACK, HOLD
`endif
  } rxState_t;

  rxState_t stateQ, stateNext;

  logic [DIV_W-1:0] divCnt, divTop;
  logic             tick;
  logic             syncQ1, syncQ2;
  logic [2:0]       sampQ;
  logic             lineF;
  logic [OVS_W-1:0] ovsCnt;
  logic             ovsLast;
  logic [2:0]       bitCnt;
  logic [GAP_W-1:0] gapCnt;
  logic [7:0]       shiftQ;
  logic             parErrQ;
  logic             invQ, parEnQ, parOddQ;

  // Oversample tick; >= lets the counter recover at once when cfg_div shrinks below it
  assign divTop = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
  assign tick   = (divCnt >= divTop);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst)       divCnt <= '0;
    else if (tick) divCnt <= '0;
    else           divCnt <= divCnt + DIV_W'(1);
  end

  // Line conditioning: 2-flop synchroniser, then 3-sample majority on ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      syncQ1 <= 1'b1;
      syncQ2 <= 1'b1;
      sampQ  <= 3'b111;
    end else begin
      syncQ1 <= rx;
      syncQ2 <= syncQ1;
      if (tick) sampQ <= {sampQ[1:0], syncQ2};
    end
  end

  assign lineF   = (sampQ[0] & sampQ[1]) | (sampQ[0] & sampQ[2]) | (sampQ[1] & sampQ[2]);
  assign ovsLast = (ovsCnt == OVS_TOP);

  always_ff @(posedge clk) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateNext;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves stateNext unassigned (no latch).
    stateNext = stateQ;
    if (tick) begin
      case (stateQ)
        IDLE:    if (!lineF) stateNext = START;
        START:   if (ovsCnt == HALF_TOP) stateNext = lineF ? IDLE : DATA;
        DATA:    if (ovsLast && bitCnt == 3'd7) stateNext = PARITY;
        PARITY:  if (ovsLast) stateNext = STOP;
`ifdef SCARD_RX_NACK_EN
        STOP:    if (ovsLast) stateNext = parErrQ ? NACK : IDLE;
        NACK:    if (ovsLast) stateNext = HOLD;
        HOLD:    if (ovsLast) stateNext = IDLE;
`else
        STOP:    if (ovsLast) stateNext = IDLE;
`endif
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovsCnt     <= '0;
      bitCnt     <= '0;
      gapCnt     <= '0;
      shiftQ     <= '0;
      parErrQ    <= 1'b0;
      invQ       <= 1'b0;
      parEnQ     <= 1'b0;
      parOddQ    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_par_err <= 1'b0;
      rx_frm_err <= 1'b0;
      rx_eop     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_eop   <= 1'b0;

      if (stateQ != IDLE) begin
        gapCnt <= '0;
      end else if (tick && !rx_idle) begin
        gapCnt <= gapCnt + GAP_W'(1);
        if (gapCnt == GAP_LAST) rx_eop <= 1'b1;
      end

      if (tick) begin
        case (stateQ)
          IDLE: begin
            ovsCnt <= '0;
            bitCnt <= '0;
            // Conventions are frozen for the whole character at the start edge
            if (!lineF) begin
              invQ    <= cfg_inverse;
              parEnQ  <= cfg_par_en;
              parOddQ <= cfg_par_odd;
            end
          end
          START: ovsCnt <= (ovsCnt == HALF_TOP) ? '0 : ovsCnt + OVS_W'(1);
          DATA: begin
            ovsCnt <= ovsLast ? '0 : ovsCnt + OVS_W'(1);
            if (ovsLast) begin
              bitCnt <= bitCnt + 3'd1;
              shiftQ <= invQ ? {shiftQ[6:0], ~lineF} : {lineF, shiftQ[7:1]};
            end
          end
          PARITY: begin
            ovsCnt <= ovsLast ? '0 : ovsCnt + OVS_W'(1);
            if (ovsLast) parErrQ <= parEnQ & ((^shiftQ ^ (lineF ^ invQ)) != parOddQ);
          end
          STOP: begin
            ovsCnt <= ovsLast ? '0 : ovsCnt + OVS_W'(1);
            if (ovsLast) begin
              rx_data    <= shiftQ;
              rx_par_err <= parErrQ;
              rx_frm_err <= ~lineF;
              rx_valid   <= 1'b1;
            end
          end
          default: ovsCnt <= ovsLast ? '0 : ovsCnt + OVS_W'(1);
        endcase
      end
    end
  end

  always_comb begin
    rx_idle = (gapCnt == GAP_FULL);
    nack_oe = 1'b0;
`ifdef SCARD_RX_NACK_EN
    // Gated by rst so the line is released in the same cycle reset arrives
    nack_oe = (stateQ == NACK) && !rst;
`endif
  end

endmodule
